// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_bin
//  Purpose  : Sequential 4-digit BCD to unsigned binary converter. Digits are
//             folded in most-significant first using Horner accumulation
//             (acc*10 + digit), one digit per clock, behind a start/busy/done
//             handshake. Any captured digit above 9 raises err and forces the
//             reported value to zero, without shortening the conversion.
//  Ports    : clk    - rising-edge clock
//             rst    - asynchronous active-high reset
//             start  - conversion request, sampled only while idle
//             milh   - thousands digit (BCD)
//             cent   - hundreds digit (BCD)
//             dec    - tens digit (BCD)
//             un     - units digit (BCD)
//             bin    - converted value, held until the next done
//             busy   - conversion in progress
//             done   - one-cycle pulse, bin/err updated on this cycle
//             err    - a captured digit was > 9, held until the next done
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin #(
    parameter int BIN_W = 16  // must be >= 14 to hold 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       milh,
    input  logic [3:0]       cent,
    input  logic [3:0]       dec,
    input  logic [3:0]       un,
    output logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    localparam logic [1:0] c_IDX_FIRST = 2'd3;  // milh is consumed first

    state_t             r_state;
    logic [15:0]        r_digits;   // {milh, cent, dec, un} as captured
    logic               r_bad;
    logic [BIN_W-1:0]   r_acc;
    logic [1:0]         r_idx;

    logic               w_bad_in;
    logic [3:0]         w_digit;
    logic [BIN_W-1:0]   w_acc_next;

    assign w_bad_in = (milh > 4'd9) || (cent > 4'd9) ||
                      (dec  > 4'd9) || (un   > 4'd9);

    // idx 3..0 selects milh..un out of the packed capture register.
    assign w_digit = r_digits[{r_idx, 2'b00} +: 4];

    // acc*10 as a shift-add pair; 9999 fits in 14 bits so no overflow for
    // valid digits, and invalid results are discarded anyway.
    assign w_acc_next = (r_acc << 3) + (r_acc << 1)
                      + {{(BIN_W-4){1'b0}}, w_digit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_digits <= '0;
            r_bad    <= 1'b0;
            r_acc    <= '0;
            r_idx    <= c_IDX_FIRST;
            bin      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_digits <= {milh, cent, dec, un};
                        r_bad    <= w_bad_in;
                        r_acc    <= '0;
                        r_idx    <= c_IDX_FIRST;
                        busy     <= 1'b1;
                        r_state  <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx - 2'd1;
                    if (r_idx == 2'd0) begin
                        bin     <= r_bad ? '0 : w_acc_next;
                        err     <= r_bad;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_idx   <= c_IDX_FIRST;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_to_bin
//  Purpose  : Self-checking bench for bcd_to_bin. Expected values come from a
//             decimal arithmetic model (m*1000 + c*100 + d*10 + u, zero with
//             err when any digit exceeds 9) and fixed cycle timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;

    localparam int BIN_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [3:0]       milh;
    logic [3:0]       cent;
    logic [3:0]       dec;
    logic [3:0]       un;
    logic [BIN_W-1:0] bin;
    logic             busy;
    logic             done;
    logic             err;

    int n_tests;
    int n_fail;
    int last_bin;
    bit last_err;

    bcd_to_bin #(.BIN_W(BIN_W)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .milh  (milh),
        .cent  (cent),
        .dec   (dec),
        .un    (un),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    // Decimal reference model.
    function automatic void model(input int m, input int c, input int d, input int u,
                                  output int val, output bit bad);
        bad = (m > 9) || (c > 9) || (d > 9) || (u > 9);
        val = bad ? 0 : (m * 1000 + c * 100 + d * 10 + u);
    endfunction

    task automatic scramble();
        milh = 4'($urandom_range(0, 15));
        cent = 4'($urandom_range(0, 15));
        dec  = 4'($urandom_range(0, 15));
        un   = 4'($urandom_range(0, 15));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full conversion starting from IDLE; caller is 1 time unit past an edge.
    task automatic convert(input int m, input int c, input int d, input int u);
        int  ev;
        bit  eb;
        model(m, c, d, u, ev, eb);
        milh  = 4'(m);
        cent  = 4'(c);
        dec   = 4'(d);
        un    = 4'(u);
        start = 1'b1;
        step();
        start = 1'b0;
        scramble();
        check("busy_after_capture", {31'b0, busy}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            scramble();
            if (k < 4) begin
                check("busy_mid", {31'b0, busy}, 32'd1);
                check("done_mid", {31'b0, done}, 32'd0);
                check("bin_hold", 32'(bin), 32'(last_bin));
                check("err_hold", {31'b0, err}, {31'b0, last_err});
            end else begin
                check("done_pulse", {31'b0, done}, 32'd1);
                check("busy_end", {31'b0, busy}, 32'd0);
                check("bin_result", 32'(bin), 32'(ev));
                check("err_result", {31'b0, err}, {31'b0, eb});
            end
        end
        last_bin = ev;
        last_err = eb;
        step();
        check("done_low_after", {31'b0, done}, 32'd0);
        check("bin_after", 32'(bin), 32'(last_bin));
    endtask

    initial begin
        int ev;
        bit eb;
        int seen_done;
        n_tests  = 0;
        n_fail   = 0;
        last_bin = 0;
        last_err = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        milh  = '0;
        cent  = '0;
        dec   = '0;
        un    = '0;

        #3;
        check("rst_bin",  32'(bin), 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err",  {31'b0, err},  32'd0);
        step();
        rst = 1'b0;
        step();
        check("idle_busy", {31'b0, busy}, 32'd0);

        // Directed values.
        convert(2, 5, 7, 8);
        convert(9, 9, 9, 9);
        convert(0, 0, 0, 0);
        convert(1, 10, 1, 1);
        convert(0, 0, 4, 2);

        // Back-to-back with start held: 1234 then 0056.
        milh = 4'd1; cent = 4'd2; dec = 4'd3; un = 4'd4;
        start = 1'b1;
        for (int r = 0; r < 2; r++) begin
            step();
            check("b2b_busy", {31'b0, busy}, 32'd1);
            for (int k = 1; k <= 4; k++) begin
                if (k < 4) scramble();
                else if (r == 0) begin
                    milh = 4'd0; cent = 4'd0; dec = 4'd5; un = 4'd6;
                end
                step();
                if (k < 4) check("b2b_done_mid", {31'b0, done}, 32'd0);
            end
            check("b2b_done", {31'b0, done}, 32'd1);
            check("b2b_bin", 32'(bin), (r == 0) ? 32'd1234 : 32'd56);
            if (r == 0) begin
                milh = 4'd0; cent = 4'd0; dec = 4'd5; un = 4'd6;
            end
        end
        start = 1'b0;
        step();
        check("b2b_idle", {31'b0, busy}, 32'd0);
        last_bin = 56;
        last_err = 1'b0;

        // Start pulsed while busy must be ignored.
        milh = 4'd3; cent = 4'd1; dec = 4'd4; un = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        milh = 4'd7; cent = 4'd7; dec = 4'd7; un = 4'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done) begin
                seen_done++;
                check("ign_bin", 32'(bin), 32'd3141);
            end
        end
        check("ign_done_count", 32'(seen_done), 32'd1);
        check("ign_bin_hold", 32'(bin), 32'd3141);
        last_bin = 3141;

        // Reset two cycles into a conversion.
        milh = 4'd5; cent = 4'd5; dec = 4'd5; un = 4'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_bin",  32'(bin), 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_err",  {31'b0, err},  32'd0);
        step();
        rst = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (done) seen_done++;
        end
        check("mid_rst_no_done", 32'(seen_done), 32'd0);
        last_bin = 0;
        last_err = 1'b0;
        convert(0, 1, 0, 0);

        // Randomised conversions, mostly valid digits.
        for (int t = 0; t < 40; t++) begin
            int dg[4];
            for (int j = 0; j < 4; j++)
                dg[j] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                                    : int'($urandom_range(0, 9));
            convert(dg[0], dg[1], dg[2], dg[3]);
        end

        model(9, 8, 7, 6, ev, eb);
        convert(9, 8, 7, 6);
        check("final_bin", 32'(bin), 32'(ev));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute watchdog so the run always terminates.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: timeout reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
